// File: rtl/seven_seg_rx.sv
// Seven-segment receiver: qualifies each segment pattern by stability and
// decodes it back to the 3-bit display code, flagging patterns the driver never emits.
module seven_seg_rx #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seg_a,
    input  logic             seg_b,
    input  logic             seg_c,
    input  logic             seg_d,
    input  logic             seg_e,
    input  logic             seg_f,
    input  logic             seg_g,
    output logic [2:0]       code,
    output logic             code_valid,
    output logic             code_other,
    output logic             stable,
    output logic             invalid,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        LOCKED  = 2'd1,
        INVALID = 2'd2
    } state_t;

    // Returns {legal, other, code}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b1111110: r = 5'b10_000;
            7'b0110000: r = 5'b10_001;
            7'b1101101: r = 5'b10_010;
            7'b1111001: r = 5'b10_011;
            7'b1001111: r = 5'b11_100;
            default:    r = 5'b00_000;
        endcase
        return r;
    endfunction

    logic [6:0] pat;
    logic [6:0] seg_p0;
    logic [7:0] cnt_p0;
    logic [4:0] dec_p0;
    state_t     state;

    assign pat    = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
    assign dec_p0 = decode(seg_p0);

    // Stage 0: sample the lines and count consecutive identical samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_p0 <= '0;
            cnt_p0 <= '0;
        end else begin
            seg_p0 <= pat;
            if (cnt_p0 == 8'd0 || pat != seg_p0)
                cnt_p0 <= 8'd1;
            else if (cnt_p0 < CNT_MAX)
                cnt_p0 <= cnt_p0 + 8'd1;
        end
    end

    // Stage 1: lock/invalid FSM on the registered sample and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SETTLE;
            code       <= 3'b000;
            code_other <= 1'b0;
            code_valid <= 1'b0;
            stable     <= 1'b0;
            invalid    <= 1'b0;
            err_count  <= '0;
        end else begin
            code_valid <= 1'b0;
            case (state)
                SETTLE: begin
                    if (cnt_p0 == CNT_MAX) begin
                        if (dec_p0[4]) begin
                            state      <= LOCKED;
                            stable     <= 1'b1;
                            code       <= dec_p0[2:0];
                            code_other <= dec_p0[3];
                            code_valid <= 1'b1;
                        end else begin
                            state   <= INVALID;
                            invalid <= 1'b1;
                            if (err_count != {ERR_W{1'b1}})
                                err_count <= err_count + {{(ERR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                LOCKED, INVALID: begin
                    if (cnt_p0 < CNT_MAX) begin
                        state   <= SETTLE;
                        stable  <= 1'b0;
                        invalid <= 1'b0;
                    end
                end
                default: begin
                    state   <= SETTLE;
                    stable  <= 1'b0;
                    invalid <= 1'b0;
                end
            endcase
        end
    end

endmodule
